// File: rtl/demosaic_pkg.sv
// Shared constants and helpers for the RGB -> YCbCr colour-space converter.
// Coefficients are 8.8 fixed point (scaled by 256) BT.601 full-range values.
package demosaic_pkg;

  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int ACC_W = 18;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t C_Y_R  =  18'sd77;
  localparam acc_t C_Y_G  =  18'sd150;
  localparam acc_t C_Y_B  =  18'sd29;
  localparam acc_t C_CB_R = -18'sd43;
  localparam acc_t C_CB_G = -18'sd85;
  localparam acc_t C_CB_B =  18'sd128;
  localparam acc_t C_CR_R =  18'sd128;
  localparam acc_t C_CR_G = -18'sd107;
  localparam acc_t C_CR_B = -18'sd21;

  // Half an LSB after the >>8, so the floor shift rounds to nearest.
  localparam acc_t ROUND  = 18'sd128;
  // Chroma mid-scale offset.
  localparam acc_t OFFSET = 18'sd128;

  typedef struct packed {
    acc_t yr;
    acc_t yg;
    acc_t yb;
    acc_t cbr;
    acc_t cbg;
    acc_t cbb;
    acc_t crr;
    acc_t crg;
    acc_t crb;
  } prod_t;

  typedef struct packed {
    acc_t y;
    acc_t cb;
    acc_t cr;
  } ycc_acc_t;

  // Zero-extend an 8-bit channel into the signed accumulator width.
  function automatic acc_t widen(input logic [CH_W-1:0] c);
    return acc_t'({{(ACC_W-CH_W){1'b0}}, c});
  endfunction

  // Clamp a signed intermediate to the unsigned 8-bit channel range.
  function automatic logic [CH_W-1:0] sat_ch(input acc_t v);
    if (v < 18'sd0) begin
      return '0;
    end else if (v > 18'sd255) begin
      return '1;
    end else begin
      return v[CH_W-1:0];
    end
  endfunction

endpackage

// File: rtl/axis_geom_check.sv
// Frame geometry checker for an AXI-Stream video input. Tracks the
// column/row of every accepted pixel and raises sticky flags when the
// start-of-frame (tuser) or end-of-line (tlast) markers disagree with
// the expected position. A tuser pixel resynchronises the counters.
module axis_geom_check #(
  parameter int Nrows = 349,
  parameter int Ncol  = 349
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic tuser,
  input  logic tlast,
  output logic err_sof,
  output logic err_eol
);

  localparam int CW = (Ncol  > 1) ? $clog2(Ncol)  : 1;
  localparam int RW = (Nrows > 1) ? $clog2(Nrows) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(Ncol - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(Nrows - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          at_origin;
  logic          at_eol;

  assign at_origin = (col == '0) && (row == '0);
  assign at_eol    = (col == COL_LAST);

  // Position tracking and sticky error capture on each accepted pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row     <= '0;
      err_sof <= 1'b0;
      err_eol <= 1'b0;
    end else if (accept) begin
      if (tuser != at_origin) err_sof <= 1'b1;
      if (tlast != at_eol)    err_eol <= 1'b1;
      if (tuser) begin
        col <= CW'(1);
        row <= '0;
      end else if (at_eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_to_ycbcr.sv
// RGB888 -> YCbCr888 converter, AXI-Stream in and out.
// Three stages (products, sums, shift/offset/clamp) advance together on a
// single enable, so the whole pipe stalls as one when the output is blocked.
// Optional frame geometry checking is built when RGB_TO_YCBCR_GEOM_CHECK_EN
// is defined; otherwise err_sof/err_eol are constant 0.
module rgb_to_ycbcr
  import demosaic_pkg::*;
#(
  parameter int Nrows = 349,
  parameter int Ncol  = 349
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic [PIX_W-1:0] s_axis_tdata,
  output logic             s_axis_tready,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic [PIX_W-1:0] m_axis_tdata,
  input  logic             m_axis_tready,
  output logic             err_sof,
  output logic             err_eol
);

  logic     en;
  acc_t     r_s, g_s, b_s;
  logic     v1, u1, l1;
  prod_t    p1;
  logic     v2, u2, l2;
  ycc_acc_t s2;

  assign en            = m_axis_tready | ~m_axis_tvalid;
  assign s_axis_tready = en;

  assign r_s = widen(s_axis_tdata[23:16]);
  assign g_s = widen(s_axis_tdata[15:8]);
  assign b_s = widen(s_axis_tdata[7:0]);

  // Stage 1: nine coefficient products plus sideband.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      u1 <= 1'b0;
      l1 <= 1'b0;
      p1 <= '0;
    end else if (en) begin
      v1     <= s_axis_tvalid;
      u1     <= s_axis_tuser;
      l1     <= s_axis_tlast;
      p1.yr  <= r_s * C_Y_R;
      p1.yg  <= g_s * C_Y_G;
      p1.yb  <= b_s * C_Y_B;
      p1.cbr <= r_s * C_CB_R;
      p1.cbg <= g_s * C_CB_G;
      p1.cbb <= b_s * C_CB_B;
      p1.crr <= r_s * C_CR_R;
      p1.crg <= g_s * C_CR_G;
      p1.crb <= b_s * C_CR_B;
    end
  end

  // Stage 2: per-component sums including the rounding constant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2 <= 1'b0;
      u2 <= 1'b0;
      l2 <= 1'b0;
      s2 <= '0;
    end else if (en) begin
      v2    <= v1;
      u2    <= u1;
      l2    <= l1;
      s2.y  <= p1.yr  + p1.yg  + p1.yb  + ROUND;
      s2.cb <= p1.cbr + p1.cbg + p1.cbb + ROUND;
      s2.cr <= p1.crr + p1.crg + p1.crb + ROUND;
    end
  end

  // Stage 3: floor shift, chroma offset, clamp into the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (en) begin
      m_axis_tvalid <= v2;
      m_axis_tuser  <= u2;
      m_axis_tlast  <= l2;
      m_axis_tdata  <= {sat_ch(s2.y >>> 8),
                        sat_ch((s2.cb >>> 8) + OFFSET),
                        sat_ch((s2.cr >>> 8) + OFFSET)};
    end
  end

`ifdef RGB_TO_YCBCR_GEOM_CHECK_EN
  axis_geom_check #(
    .Nrows (Nrows),
    .Ncol  (Ncol)
  ) u_geom_check (
    .clk     (clk),
    .rst     (rst),
    .accept  (s_axis_tvalid & en),
    .tuser   (s_axis_tuser),
    .tlast   (s_axis_tlast),
    .err_sof (err_sof),
    .err_eol (err_eol)
  );
`else
  assign err_sof = 1'b0;
  assign err_eol = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Scoreboard bench for rgb_to_ycbcr on a 4x4 frame geometry.
module tb_rgb_to_ycbcr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tready;
  logic        m_tvalid, m_tuser, m_tlast;
  logic [23:0] m_tdata;
  logic        m_tready = 1'b1;
  logic        err_sof, err_eol;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    bit          lat;
    int          exp_edge;
  } exp_t;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  bit   rand_rdy = 1'b0;

  // Hand-computed RGB -> YCbCr pairs.
  logic [23:0] vin [16] = '{
    24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'h808080, 24'h010101, 24'h010000,
    24'h000001, 24'h000100, 24'hFFFF00, 24'h00FFFF,
    24'hFF00FF, 24'h000080, 24'h800000, 24'h008000};
  logic [23:0] vout [16] = '{
    24'hFF8080, 24'h008080, 24'h4D55FF, 24'h952B15,
    24'h1DFF6B, 24'h808080, 24'h018080, 24'h008081,
    24'h008180, 24'h018080, 24'hE20195, 24'hB2AB01,
    24'h6AD5EB, 24'h0FC076, 24'h276BC0, 24'h4B564B};

  rgb_to_ycbcr #(.Nrows(4), .Ncol(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tready (m_tready),
    .err_sof       (err_sof),
    .err_eol       (err_eol)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake, checks hold under stall.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst && m_tvalid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", m_tdata);
        end else if (m_tready) begin
          x = q.pop_front();
          chk("tdata", m_tdata, x.data);
          chk("tuser", m_tuser, x.user);
          chk("tlast", m_tlast, x.last);
          if (x.lat) chk("latency_edge", edge_cnt, x.exp_edge);
        end else begin
          chk("stall_hold_data", m_tdata, q[0].data);
          chk("stall_hold_side", {m_tuser, m_tlast}, {q[0].user, q[0].last});
        end
      end
    end
  end

  task automatic send(input logic [23:0] d, input logic u, input logic l,
                      input logic [23:0] e, input bit lat);
    exp_t x;
    bit   done;
    done     = 1'b0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (s_tready) begin
        x.data     = e;
        x.user     = u;
        x.last     = l;
        x.lat      = lat;
        x.exp_edge = edge_cnt + 3;
        q.push_back(x);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no ready expected ready");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, checked while held and after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", s_tready, 1);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_side", {m_tuser, m_tlast}, 2'b00);
    chk("rst_err", {err_sof, err_eol}, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", s_tready, 1);
    chk("post_rst_m_tvalid", m_tvalid, 0);

    // Directed single pixels with latency check.
    send(24'hFFFFFF, 1'b0, 1'b0, 24'hFF8080, 1'b1);
    drain();
    send(24'h000000, 1'b0, 1'b0, 24'h008080, 1'b1);
    drain();
    send(24'hFF0000, 1'b0, 1'b0, 24'h4D55FF, 1'b1);
    drain();

    // 4x4 frame under random backpressure and random input gaps.
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(vin[i], 1'(i == 0), 1'(i % 4 == 3), vout[i], 1'b0);
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    m_tready = 1'b1;

    // Back-to-back frame at full rate: fixed latency implies 1 pixel/clk.
    for (int i = 0; i < 16; i++)
      send(vin[15 - i], 1'(i == 0), 1'(i % 4 == 3), vout[15 - i], 1'b1);
    drain();
    chk("frames_err", {err_sof, err_eol}, 2'b00);

`ifdef RGB_TO_YCBCR_GEOM_CHECK_EN
    // tlast on column 2 of a 4-wide line.
    do_reset();
    for (int i = 0; i < 4; i++)
      send(vin[i], 1'(i == 0), 1'(i == 2), vout[i], 1'b1);
    drain();
    chk("geom_err_eol", err_eol, 1);
    chk("geom_err_sof", err_sof, 0);
    for (int i = 4; i < 8; i++)
      send(vin[i], 1'b0, 1'(i == 7), vout[i], 1'b1);
    drain();
    chk("geom_err_eol_sticky", err_eol, 1);
    chk("geom_err_sof_after", err_sof, 0);
`else
    // Malformed tuser with no checker: flags stay low, data unchanged.
    do_reset();
    for (int i = 0; i < 4; i++)
      send(vin[i + 4], 1'(i == 2), 1'(i == 1), vout[i + 4], 1'b1);
    drain();
    chk("nogeom_err_sof", err_sof, 0);
    chk("nogeom_err_eol", err_eol, 0);
`endif

    // Reset mid-frame with pixels in flight and a stalled output.
    do_reset();
    m_tready = 1'b0;
    send(vin[10], 1'b1, 1'b0, vout[10], 1'b0);
    send(vin[11], 1'b0, 1'b0, vout[11], 1'b0);
    send(vin[12], 1'b0, 1'b0, vout[12], 1'b0);
    chk("pre_reset_m_tvalid", m_tvalid, 1);
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s_tready", s_tready, 1);
    chk("midrst_m_tdata", m_tdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_m_tvalid", m_tvalid, 0);
    send(24'h00FFFF, 1'b1, 1'b0, 24'hB2AB01, 1'b1);
    drain();
    chk("post_midrst_err", {err_sof, err_eol}, 2'b00);
    chk("final_m_tvalid", m_tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_to_ycbcr.md
RGB_TO_YCBCR -- requirements
Module: rgb_to_ycbcr

Interface
REQ-001 SHALL have parameter Nrows, default 349, lines per frame.
REQ-002 SHALL have parameter Ncol, default 349, pixels per line.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s_axis_tvalid/s_axis_tuser/s_axis_tlast, input, 1 each, AXI-Stream slave: valid, start-of-frame, end-of-line.
REQ-006 SHALL have port s_axis_tdata, input, 24, pixel packed R[23:16], G[15:8], B[7:0] (demosaicing output format).
REQ-007 SHALL have port s_axis_tready, output, 1, slave ready.
REQ-008 SHALL have ports m_axis_tvalid/m_axis_tuser/m_axis_tlast, output, 1 each, master valid/SOF/EOL.
REQ-009 SHALL have port m_axis_tdata, output, 24, packed Y[23:16], Cb[15:8], Cr[7:0].
REQ-010 SHALL have port m_axis_tready, input, 1, master ready.
REQ-011 SHALL have ports err_sof and err_eol, output, 1 each, sticky geometry-error flags.

Function
REQ-012 SHALL compute Y = (77R + 150G + 29B + 128) >> 8.
REQ-013 SHALL compute Cb = ((-43R - 85G + 128B + 128) >>> 8) + 128, Cr = ((128R - 107G - 21B + 128) >>> 8) + 128, signed 18-bit intermediates, arithmetic shift (floor).
REQ-014 SHALL saturate each result to 0..255.
REQ-015 SHALL be a 3-stage pipeline: products, sums, shift/offset/clamp; latency exactly 3 clk from input handshake to m_axis_tvalid when m_axis_tready is held high.
REQ-016 SHALL carry tuser and tlast through the same 3 stages, aligned with their pixel.
REQ-017 SHALL use a single advance enable en = m_axis_tready | ~m_axis_tvalid; all stages load only when en=1.
REQ-018 SHALL drive s_axis_tready = en combinationally.
REQ-019 SHALL mark a stage bubble (valid=0) when its input valid was 0 at an advance.
REQ-020 SHALL hold m_axis_tdata/tuser/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 SHALL sustain 1 pixel/clk throughput with m_axis_tready constantly high; no pixel dropped or duplicated under any backpressure pattern.

Reset
REQ-022 SHALL, on rst=0, immediately clear all stage valids, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata (to 0), err_sof, err_eol, and geometry counters.
REQ-023 SHALL discard in-flight pixels on reset mid-frame; first pixel accepted after release is treated as column 0, row 0.
REQ-024 SHALL drive s_axis_tready=1 during and after reset (pipeline empty).

Configuration
REQ-025 SHALL, with macro RGB_TO_YCBCR_GEOM_CHECK_EN defined, count accepted input pixels (column 0..Ncol-1, row 0..Nrows-1, wrap to 0/0 after last pixel of frame).
REQ-026 SHALL with the macro set err_sof when tuser=1 at a non-(0,0) position or tuser=0 at (0,0); set err_eol when tlast disagrees with column==Ncol-1; both sticky until reset.
REQ-027 SHALL with the macro resynchronise counters to (1,0) after an accepted tuser pixel.
REQ-028 SHALL without the macro omit counters; err_sof and err_eol tied to 0.

Structure
REQ-029 SHALL place coefficients, rounding constant, offset 128, pixel/channel widths in shared package demosaic_pkg.
REQ-030 SHALL implement the geometry checker as sub-module axis_geom_check (Nrows, Ncol), instantiated only under the macro.

Verification
REQ-031 SHALL test input 0xFFFFFF -> output 0xFF8080; 0x000000 -> 0x008080, each 3 clk after handshake.
REQ-032 SHALL test input 0xFF0000 -> 0x4D55FF (Cr saturation).
REQ-033 SHALL test 4x4 frame stream with m_axis_tready toggling pseudo-randomly -> output sequence identical to model, tuser on pixel 0, tlast every 4th.
REQ-034 SHALL test, macro on, tlast on column 2 of Ncol=4 -> err_eol=1 and stays 1; err_sof=0.
REQ-035 SHALL test rst=0 asserted mid-frame with 2 pixels in flight -> m_axis_tvalid=0 immediately, no stale pixel emitted after release.
REQ-036 SHALL test, macro off, malformed tuser -> err_sof remains 0, data path unchanged.
